// File: rtl/sqrt_result_pack_if.sv
// Stream bundle between the FP16 sqrt iterator, the result packer and its consumer.
// master: the packer (drives in_ready and the output stream); slave: the environment.
interface sqrt_result_pack_if;
  logic        it_valid;
  logic        result;
  logic        sign_in;
  logic [6:0]  exp_in;
  logic [10:0] mant_in;
  logic        is_nan_in;
  logic        is_pinf_in;
  logic        is_ninf_in;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    input  it_valid, result, sign_in, exp_in, mant_in,
    input  is_nan_in, is_pinf_in, is_ninf_in, out_ready,
    output in_ready, out_valid, out_data
  );

  modport slave (
    output it_valid, result, sign_in, exp_in, mant_in,
    output is_nan_in, is_pinf_in, is_ninf_in, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sqrt_result_pack.sv
// Packs finished FP16 sqrt results into binary16 words and queues them in a
// small FIFO toward a valid/ready consumer, with drop detection and a push counter.
module sqrt_result_pack #(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sqrt_result_pack_if.master   bus,
  output logic [CNT_WIDTH-1:0] result_count,
  output logic                 overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wptr, rptr, rptr_nxt;
  logic [OW-1:0] occ, occ_nxt;
  logic [15:0]   out_data_q, head_nxt, packed_word;
  logic          out_valid_q, in_ready_q;
  logic          strobe, full, pop, push, drop;

  logic signed [6:0] exp_s;
  logic        [6:0] biased;

  // Binary16 packing; special flags take priority over the numeric fields.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    packed_word = {bus.sign_in, 5'h00, bus.mant_in[9:0]};
    exp_s       = $signed(bus.exp_in);
    biased      = bus.exp_in + 7'd15;
    if (bus.is_nan_in || bus.is_ninf_in)
      packed_word = {bus.sign_in, 5'h1F, 10'h200};
    else if (bus.is_pinf_in)
      packed_word = 16'h7C00;
    else if (exp_s == -7'sd15 && bus.mant_in == 11'd0)
      packed_word = {bus.sign_in, 15'h0000};
    else if (exp_s > 7'sd15)
      packed_word = {bus.sign_in, 5'h1F, 10'h000};
    else if (exp_s <= -7'sd15)
      packed_word = {bus.sign_in, 5'h00, bus.mant_in[9:0]};
    else
      packed_word = {bus.sign_in, biased[4:0], bus.mant_in[9:0]};
  end

  always_comb begin
    strobe   = bus.it_valid & bus.result;
    full     = (occ == OW'(DEPTH));
    pop      = out_valid_q & bus.out_ready;
    push     = strobe & (~full | pop);
    drop     = strobe & full & ~pop;
    rptr_nxt = pop ? rptr + PW'(1) : rptr;
    occ_nxt  = occ;
    if (push && !pop)
      occ_nxt = occ + OW'(1);
    else if (pop && !push)
      occ_nxt = occ - OW'(1);
    // A word written this cycle into the slot that becomes head bypasses the array read.
    head_nxt = (push && wptr == rptr_nxt) ? packed_word : mem[rptr_nxt];
  end

  // NOTE: the storage array carries no reset; pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= packed_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      occ          <= '0;
      out_data_q   <= 16'h0000;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      result_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push) begin
        wptr         <= wptr + PW'(1);
        result_count <= result_count + CNT_WIDTH'(1);
      end
      rptr        <= rptr_nxt;
      occ         <= occ_nxt;
      out_valid_q <= (occ_nxt != '0);
      in_ready_q  <= (occ_nxt != OW'(DEPTH));
      // When the FIFO drains, out_data keeps the last word presented.
      if (occ_nxt != '0)
        out_data_q <= head_nxt;
      if (drop)
        overflow <= 1'b1;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_sqrt_result_pack.sv
// Directed self-checking bench for sqrt_result_pack: packing, back-pressure,
// full-with-pop, counter wrap and synchronous reset in mid-operation.
module tb_sqrt_result_pack;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] result_count;
  logic       overflow;
  int         n_cmp = 0;
  int         n_err = 0;

  sqrt_result_pack_if bus ();

  sqrt_result_pack #(.DEPTH(2), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .result_count (result_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [6:0] e, input logic [10:0] m,
                       input logic nan, input logic pinf, input logic ninf);
    bus.it_valid   = 1'b1;
    bus.result     = 1'b1;
    bus.sign_in    = s;
    bus.exp_in     = e;
    bus.mant_in    = m;
    bus.is_nan_in  = nan;
    bus.is_pinf_in = pinf;
    bus.is_ninf_in = ninf;
  endtask

  task automatic idle();
    bus.it_valid   = 1'b0;
    bus.result     = 1'b0;
    bus.is_nan_in  = 1'b0;
    bus.is_pinf_in = 1'b0;
    bus.is_ninf_in = 1'b0;
  endtask

  // One strobe cycle, then the result is checked as the new head word.
  task automatic strobe_check(input string tag, input logic s, input logic [6:0] e,
                              input logic [10:0] m, input logic nan, input logic pinf,
                              input logic ninf, input logic [15:0] exp_word);
    drive(s, e, m, nan, pinf, ninf);
    tick();
    idle();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp_word));
  endtask

  task automatic strobe_only(input logic [6:0] e, input logic [10:0] m);
    drive(1'b0, e, m, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = 7'd0;
    bus.mant_in   = 11'd0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h0000);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_count", 32'(result_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Iterator busy: it_valid without result, flags set, must be ignored.
    bus.it_valid  = 1'b1;
    bus.is_nan_in = 1'b1;
    tick();
    idle();
    check("busy_out_valid", 32'(bus.out_valid), 32'd0);
    check("busy_count", 32'(result_count), 32'd0);

    // Packing with a consumer that is always ready.
    bus.out_ready = 1'b1;
    strobe_check("sqrt4", 1'b0, 7'd1, 11'h400, 1'b0, 1'b0, 1'b0, 16'h4000);
    check("sqrt4_count", 32'(result_count), 32'd1);
    strobe_check("sqrt2", 1'b0, 7'd0, 11'h5A8, 1'b0, 1'b0, 1'b0, 16'h3DA8);
    strobe_check("nan", 1'b0, 7'd3, 11'h400, 1'b1, 1'b0, 1'b0, 16'h7E00);
    strobe_check("ninf", 1'b1, 7'd0, 11'h000, 1'b0, 1'b0, 1'b1, 16'hFE00);
    strobe_check("pinf", 1'b1, 7'd0, 11'h000, 1'b0, 1'b1, 1'b0, 16'h7C00);
    strobe_check("nzero", 1'b1, -7'sd15, 11'h000, 1'b0, 1'b0, 1'b0, 16'h8000);
    strobe_check("exp_ovf", 1'b1, 7'd20, 11'h500, 1'b0, 1'b0, 1'b0, 16'hFC00);
    strobe_check("subn15", 1'b0, -7'sd15, 11'h523, 1'b0, 1'b0, 1'b0, 16'h0123);
    strobe_check("subn20", 1'b0, -7'sd20, 11'h7FF, 1'b0, 1'b0, 1'b0, 16'h03FF);
    strobe_check("nan_over_pinf", 1'b0, 7'd0, 11'h400, 1'b1, 1'b1, 1'b0, 16'h7E00);
    strobe_check("exp15", 1'b0, 7'd15, 11'h7FF, 1'b0, 1'b0, 1'b0, 16'h7BFF);
    tick();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_hold_data", 32'(bus.out_data), 32'h7BFF);
    check("drain_count", 32'(result_count), 32'd11);

    // Back-pressure with DEPTH=2: third strobe is dropped.
    bus.out_ready = 1'b0;
    strobe_only(7'd1, 11'h400);
    check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    strobe_only(7'd0, 11'h400);
    check("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp2_overflow", 32'(overflow), 32'd0);
    strobe_only(7'd0, 11'h5A8);
    check("bp3_overflow", 32'(overflow), 32'd1);
    check("bp3_count", 32'(result_count), 32'd13);
    check("bp3_head", 32'(bus.out_data), 32'h4000);
    tick();
    check("bp_hold_head", 32'(bus.out_data), 32'h4000);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop1_valid", 32'(bus.out_valid), 32'd1);
    check("bp_pop1_data", 32'(bus.out_data), 32'h3C00);
    check("bp_pop1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_empty_valid", 32'(bus.out_valid), 32'd0);
    check("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Clean slate, then full FIFO with a simultaneous push and pop.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_overflow", 32'(overflow), 32'd0);
    bus.out_ready = 1'b0;
    strobe_only(7'd1, 11'h400);
    strobe_only(7'd0, 11'h400);
    check("fp_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    strobe_only(7'd1, 11'h600);
    check("fp_overflow", 32'(overflow), 32'd0);
    check("fp_count", 32'(result_count), 32'd3);
    check("fp_still_full", 32'(bus.in_ready), 32'd0);
    check("fp_head1", 32'(bus.out_data), 32'h3C00);
    tick();
    check("fp_head2", 32'(bus.out_data), 32'h4200);
    check("fp_head2_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("fp_empty", 32'(bus.out_valid), 32'd0);

    // Counter wrap: 256 accepted pushes from zero bring the count back to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      strobe_only(7'd0, 11'h400 | 11'(i));
      check("wrap_data", 32'(bus.out_data), 32'h3C00 | 32'(i));
      if (i == 254)
        check("wrap_count_255", 32'(result_count), 32'd255);
    end
    check("wrap_count_0", 32'(result_count), 32'd0);
    check("wrap_overflow", 32'(overflow), 32'd0);

    // Reset mid-operation with a coincident strobe.
    bus.out_ready = 1'b0;
    tick();
    strobe_only(7'd1, 11'h400);
    strobe_only(7'd0, 11'h400);
    strobe_only(7'd0, 11'h5A8);
    check("mid_pre_overflow", 32'(overflow), 32'd1);
    rst = 1'b1;
    drive(1'b0, 7'd1, 11'h600, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_count", 32'(result_count), 32'd0);
    check("mid_overflow", 32'(overflow), 32'd0);
    check("mid_out_data", 32'(bus.out_data), 32'h0000);
    strobe_check("post_rst", 1'b0, 7'd1, 11'h400, 1'b0, 1'b0, 1'b0, 16'h4000);
    check("post_rst_count", 32'(result_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
